module_event_buffer: RTL and testbench

MODULE_EVENT_BUFFER -- requirements
Module: module_event_buffer

---
 rtl/module_event_buffer.sv | 172 +++++++++++++++++
 tb/tb_module_event_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/module_event_buffer.sv
// Event framing buffer: collects decoder words per module readout and
// appends a trailer word, stored in a first-word-fall-through FIFO.
//
// Ports:
//   clk80      : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   running    : decoder busy flag, high for one module readout
//   write      : decoder word strobe, one cycle per word
//   data       : decoder word, bits 15:13 carry the mode qualifier
//   dout       : FIFO head word (zero while empty)
//   dout_valid : dout holds a valid word
//   dout_ready : consumer accepts dout this cycle
//   fill       : number of stored words, 0..2^AW
//   evt_cnt    : completed events (trailers written), wraps
//   overflow   : sticky, a data word was dropped since reset
module module_event_buffer #(
    parameter int AW = 8
) (
    input  logic          clk80,
    input  logic          reset_n,
    input  logic          running,
    input  logic          write,
    input  logic [15:0]   data,
    output logic [15:0]   dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [AW:0]   fill,
    output logic [15:0]   evt_cnt,
    output logic          overflow
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    // Data words stop one slot short of full so the trailer fits.
    localparam logic [AW:0] DATA_LIM = (AW+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        CLOSE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [11:0]   wc;
    logic          df;

    logic          clr;
    logic          data_req;
    logic          trl_req;
    logic          drop;
    logic          pop;
    logic          push;
    logic [15:0]   push_word;

    // Next-state and event-control decode.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        data_req  = 1'b0;
        trl_req   = 1'b0;
        drop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (running) begin
                    state_nxt = COLLECT;
                    clr       = 1'b1;
                end
            end
            COLLECT: begin
                if (write) begin
                    if (fill < DATA_LIM) begin
                        data_req = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                if (!running) begin
                    state_nxt = CLOSE;
                end
            end
            CLOSE: begin
                trl_req   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk80 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign dout_valid = (fill != '0);
    assign pop        = dout_valid & dout_ready;
    // A push into a full FIFO is only possible alongside a pop, which
    // frees the slot being written in the same edge.
    assign push       = (data_req | trl_req) & ((fill != FULL) | pop);
    assign push_word  = trl_req ? {3'b011, df, wc} : data;

    // Head word is read straight from storage, giving fall-through.
    assign dout = dout_valid ? mem[rd_ptr] : 16'h0000;

    always_ff @(posedge clk80) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk80 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fill <= fill + 1'b1;
            end else if (pop && !push) begin
                fill <= fill - 1'b1;
            end
        end
    end

    // Per-event word count (saturating) and drop flag.
    always_ff @(posedge clk80 or negedge reset_n) begin
        if (!reset_n) begin
            wc <= '0;
            df <= 1'b0;
        end else if (clr) begin
            wc <= '0;
            df <= 1'b0;
        end else begin
            if (data_req && (wc != 12'hFFF)) begin
                wc <= wc + 1'b1;
            end
            if (drop) begin
                df <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk80 or negedge reset_n) begin
        if (!reset_n) begin
            evt_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (trl_req) begin
                evt_cnt <= evt_cnt + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_module_event_buffer.sv
// Directed bench for module_event_buffer with an expected-word queue
// checked against every word the consumer accepts.
module tb_module_event_buffer;

    logic        clk80;
    logic        reset_n;
    logic        running;
    logic        write;
    logic [15:0] data;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [8:0]  fill;
    logic [15:0] evt_cnt;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    module_event_buffer #(.AW(8)) dut (
        .clk80      (clk80),
        .reset_n    (reset_n),
        .running    (running),
        .write      (write),
        .data       (data),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .fill       (fill),
        .evt_cnt    (evt_cnt),
        .overflow   (overflow)
    );

    initial clk80 = 1'b0;
    always #5 clk80 = ~clk80;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk80);
        #1;
    endtask

    task automatic wr(input logic [15:0] w, input bit expect_it);
        write = 1'b1;
        data  = w;
        if (expect_it) exp_q.push_back(w);
        cyc(1);
        write = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        dout_ready = 1'b1;
        while ((exp_q.size() != 0 || fill != 0) && n < 1000) begin
            cyc(1);
            n++;
        end
        chk({tag, "_fill"}, 32'(fill), 32'd0);
        chk({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: each word the consumer takes must be the next expected.
    always @(negedge clk80) begin
        if (reset_n && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(dout), 32'hFFFF_FFFF);
            end else begin
                chk("dout_order", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        running    = 1'b0;
        write      = 1'b0;
        data       = 16'h0000;
        dout_ready = 1'b0;
        cyc(2);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_evt", 32'(evt_cnt), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        cyc(2);

        // Basic event: 3 words plus trailer, consumer always ready.
        dout_ready = 1'b1;
        running    = 1'b1;
        cyc(1);
        wr(16'hA001, 1'b1);
        cyc(1);
        wr(16'hA002, 1'b1);
        cyc(1);
        wr(16'h2345, 1'b1);
        cyc(4);
        running = 1'b0;
        exp_q.push_back(16'h6003);
        cyc(4);
        drain("evt1");
        chk("evt1_cnt", 32'(evt_cnt), 32'd1);
        chk("evt1_ovf", 32'(overflow), 32'd0);

        // Writes outside an event are ignored.
        dout_ready = 1'b0;
        wr(16'h1234, 1'b0);
        wr(16'h5678, 1'b0);
        cyc(2);
        chk("idle_fill", 32'(fill), 32'd0);
        chk("idle_valid", 32'(dout_valid), 32'd0);
        chk("idle_ovf", 32'(overflow), 32'd0);

        // Back-to-back events with running low for one cycle.
        dout_ready = 1'b1;
        running    = 1'b1;
        cyc(1);
        wr(16'h0B01, 1'b1);
        wr(16'h0B02, 1'b1);
        running = 1'b0;
        exp_q.push_back(16'h6002);
        cyc(1);
        running = 1'b1;
        cyc(2);
        wr(16'h0C01, 1'b1);
        running = 1'b0;
        exp_q.push_back(16'h6001);
        cyc(4);
        drain("b2b");
        chk("b2b_cnt", 32'(evt_cnt), 32'd3);

        // Oversized event with stalled consumer: 255 data + trailer.
        dout_ready = 1'b0;
        running    = 1'b1;
        cyc(1);
        for (int i = 0; i < 300; i++) begin
            wr(16'(16'h1000 + i), i < 255);
        end
        running = 1'b0;
        exp_q.push_back(16'h70FF);
        cyc(3);
        chk("full_fill", 32'(fill), 32'd256);
        chk("full_ovf", 32'(overflow), 32'd1);
        chk("full_valid", 32'(dout_valid), 32'd1);
        chk("hold_dout0", 32'(dout), 32'(exp_q[0]));
        cyc(2);
        chk("hold_dout1", 32'(dout), 32'(exp_q[0]));

        // Second event while full: data dropped, trailer pushed with pop.
        running = 1'b1;
        cyc(1);
        wr(16'h0D01, 1'b0);
        wr(16'h0D02, 1'b0);
        running = 1'b0;
        exp_q.push_back(16'h7000);
        cyc(1);
        dout_ready = 1'b1;
        cyc(1);
        dout_ready = 1'b0;
        chk("pushpop_fill", 32'(fill), 32'd256);
        chk("pushpop_cnt", 32'(evt_cnt), 32'd5);
        drain("wrap");

        // Reset in the middle of an event, running held high.
        dout_ready = 1'b0;
        running    = 1'b1;
        cyc(1);
        for (int i = 0; i < 5; i++) begin
            wr(16'(16'h0E00 + i), 1'b0);
        end
        chk("pre_rst_fill", 32'(fill), 32'd5);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_fill", 32'(fill), 32'd0);
        chk("mid_rst_valid", 32'(dout_valid), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_cnt", 32'(evt_cnt), 32'd0);
        cyc(1);
        reset_n    = 1'b1;
        dout_ready = 1'b1;
        cyc(1);
        wr(16'h0F01, 1'b1);
        wr(16'h0F02, 1'b1);
        running = 1'b0;
        exp_q.push_back(16'h6002);
        cyc(4);
        drain("post_rst");
        chk("post_rst_cnt", 32'(evt_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
